// File: rtl/kof_pkg.sv
// kof_pkg: shared state, result encodings and helpers for the fight game.
package kof_pkg;
  localparam int unsigned CLK_HZ = 25_000_000;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INTRO,
    ST_FIGHT,
    ST_PAUSE,
    ST_ROUND_END,
    ST_MATCH_END
  } round_state_t;
  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_P1   = 2'b01;
  localparam logic [1:0] RES_P2   = 2'b10;
  localparam logic [1:0] RES_DRAW = 2'b11;
  function automatic logic [1:0] win_lead(input logic [1:0] a, input logic [1:0] b);
    return a > b ? RES_P1 : b > a ? RES_P2 : RES_DRAW;
  endfunction
endpackage

// File: rtl/phase_delay.sv
// phase_delay: loadable down-counter; done pulses on the last cycle of a len-cycle dwell.
module phase_delay #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] len,
  output logic             done
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             armed_q, armed_d;
  always_comb begin
    cnt_d   = load ? len - CNT_W'(1) : cnt_q != '0 ? cnt_q - CNT_W'(1) : cnt_q;
    armed_d = load | (armed_q & (cnt_q != '0));
    done    = armed_q & (cnt_q == '0);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
    end
  end
endmodule

// File: rtl/round_ctrl.sv
// round_ctrl: match/round sequencer; decides round winners, counts wins to best-of-N
// and drives the round timer and player-input gating from registered outputs.
module round_ctrl
  import kof_pkg::*;
#(
  parameter int HP_W          = 8,
  parameter int ROUNDS_TO_WIN = 2,
  parameter int MAX_ROUNDS    = 5,
  parameter int INTRO_CYCLES  = 50_000_000,
  parameter int END_CYCLES    = 75_000_000
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic            pause_btn,
  input  logic [HP_W-1:0] hp1,
  input  logic [HP_W-1:0] hp2,
  input  logic            timeout,
  output logic            timer_reset,
  output logic            timer_keep,
  output logic            hp_reset,
  output logic            fight_en,
  output logic [2:0]      round_num,
  output logic [1:0]      wins1,
  output logic [1:0]      wins2,
  output logic [1:0]      round_result,
  output logic            match_over,
  output logic [1:0]      match_winner
);
  localparam logic [1:0] WIN_CAP   = 2'(ROUNDS_TO_WIN);
  localparam logic [2:0] ROUND_CAP = 3'(MAX_ROUNDS);
  round_state_t state_q, state_d;
  logic [2:0]  round_num_q, round_num_d;
  logic [1:0]  wins1_q, wins1_d, wins2_q, wins2_d;
  logic [1:0]  round_result_q, round_result_d, match_winner_q, match_winner_d;
  logic        timer_reset_q, timer_keep_q, hp_reset_q, fight_en_q, match_over_q;
  logic        ko, delay_done, delay_load;
  logic [1:0]  fight_res;
  logic [31:0] delay_len;
  phase_delay #(.CNT_W(32)) u_delay (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (delay_load),
    .len     (delay_len),
    .done    (delay_done)
  );
  always_comb begin
    ko             = hp1 == '0 || hp2 == '0;
    fight_res      = ko ? ((hp1 == '0 && hp2 == '0) ? RES_DRAW : hp1 == '0 ? RES_P2 : RES_P1)
                        : (hp1 > hp2 ? RES_P1 : hp2 > hp1 ? RES_P2 : RES_DRAW);
    state_d        = state_q;
    round_num_d    = round_num_q;
    wins1_d        = wins1_q;
    wins2_d        = wins2_q;
    round_result_d = round_result_q;
    match_winner_d = match_winner_q;
    case (state_q)
      ST_IDLE, ST_MATCH_END: if (start) begin
        state_d        = ST_INTRO;
        wins1_d        = '0;
        wins2_d        = '0;
        round_num_d    = 3'd1;
        round_result_d = RES_NONE;
      end
      ST_INTRO: if (delay_done) state_d = ST_FIGHT;
      // KO outranks timeout, which outranks pause; fight_res already encodes the KO rule
      ST_FIGHT: if (ko || timeout) begin
        state_d        = ST_ROUND_END;
        round_result_d = fight_res;
        wins1_d        = (fight_res == RES_P1 && wins1_q < WIN_CAP) ? wins1_q + 2'd1 : wins1_q;
        wins2_d        = (fight_res == RES_P2 && wins2_q < WIN_CAP) ? wins2_q + 2'd1 : wins2_q;
      end else if (pause_btn) state_d = ST_PAUSE;
      ST_PAUSE: if (pause_btn) state_d = ST_FIGHT;
      ST_ROUND_END: if (delay_done) begin
        if (wins1_q == WIN_CAP || wins2_q == WIN_CAP || round_num_q == ROUND_CAP) begin
          state_d        = ST_MATCH_END;
          match_winner_d = win_lead(wins1_q, wins2_q);
        end else begin
          state_d        = ST_INTRO;
          round_num_d    = round_num_q + 3'd1;
          round_result_d = RES_NONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    delay_load = state_d != state_q && (state_d == ST_INTRO || state_d == ST_ROUND_END);
    delay_len  = state_d == ST_INTRO ? 32'(INTRO_CYCLES) : 32'(END_CYCLES);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      round_num_q    <= '0;
      wins1_q        <= '0;
      wins2_q        <= '0;
      round_result_q <= RES_NONE;
      match_winner_q <= RES_NONE;
      timer_reset_q  <= 1'b1;
      hp_reset_q     <= 1'b1;
      timer_keep_q   <= 1'b1;
      fight_en_q     <= 1'b0;
      match_over_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      round_num_q    <= round_num_d;
      wins1_q        <= wins1_d;
      wins2_q        <= wins2_d;
      round_result_q <= round_result_d;
      match_winner_q <= match_winner_d;
      timer_reset_q  <= state_d == ST_IDLE || state_d == ST_INTRO;
      hp_reset_q     <= state_d == ST_IDLE || state_d == ST_INTRO;
      timer_keep_q   <= state_d != ST_FIGHT;
      fight_en_q     <= state_d == ST_FIGHT;
      match_over_q   <= state_d == ST_MATCH_END;
    end
  end
  assign timer_reset  = timer_reset_q;
  assign timer_keep   = timer_keep_q;
  assign hp_reset     = hp_reset_q;
  assign fight_en     = fight_en_q;
  assign match_over   = match_over_q;
  assign round_num    = round_num_q;
  assign wins1        = wins1_q;
  assign wins2        = wins2_q;
  assign round_result = round_result_q;
  assign match_winner = match_winner_q;
endmodule

// File: tb/tb_round_ctrl.sv
// tb_round_ctrl: vector table, hand sequences and randomized matches against a round-level model.
module tb_round_ctrl;
  logic       clk = 1'b0, reset_n = 1'b1, start = 1'b0, pause_btn = 1'b0, timeout = 1'b0;
  logic [7:0] hp1 = 8'd100, hp2 = 8'd100;
  logic       timer_reset, timer_keep, hp_reset, fight_en, match_over;
  logic [2:0] round_num;
  logic [1:0] wins1, wins2, round_result, match_winner;
  int errors = 0, checks = 0;

  round_ctrl #(
    .HP_W(8), .ROUNDS_TO_WIN(2), .MAX_ROUNDS(5), .INTRO_CYCLES(4), .END_CYCLES(3)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .pause_btn(pause_btn),
    .hp1(hp1), .hp2(hp2), .timeout(timeout),
    .timer_reset(timer_reset), .timer_keep(timer_keep), .hp_reset(hp_reset),
    .fight_en(fight_en), .round_num(round_num), .wins1(wins1), .wins2(wins2),
    .round_result(round_result), .match_over(match_over), .match_winner(match_winner)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] h1, h2;
    logic       to, pb;
    logic [1:0] res;
    logic       fe;
    logic [1:0] w1, w2;
  } vec_t;
  vec_t vt[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".timer_reset"}, timer_reset, 1);
    chk({tag, ".hp_reset"}, hp_reset, 1);
    chk({tag, ".timer_keep"}, timer_keep, 1);
    chk({tag, ".fight_en"}, fight_en, 0);
    chk({tag, ".match_over"}, match_over, 0);
    chk({tag, ".round_num"}, round_num, 0);
    chk({tag, ".wins1"}, wins1, 0);
    chk({tag, ".wins2"}, wins2, 0);
    chk({tag, ".round_result"}, round_result, 0);
    chk({tag, ".match_winner"}, match_winner, 0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0; start = 1'b0; pause_btn = 1'b0; timeout = 1'b0; hp1 = 8'd100; hp2 = 8'd100;
    #2;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic begin_match();
    start = 1'b1;
    tick();
    start = 1'b0;
    ticks(4);
  endtask

  function automatic int ref_result(input int a, input int b);
    if (a == 0 || b == 0) return (a == 0 && b == 0) ? 3 : (a == 0 ? 2 : 1);
    return a > b ? 1 : (b > a ? 2 : 3);
  endfunction

  task automatic rand_matches(input int n);
    int mw1, mw2, mr, a, b, exp_res, k;
    bit over;
    do_reset();
    for (int m = 0; m < n; m++) begin
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("rnd_start_wins1", wins1, 0);
      chk("rnd_start_wins2", wins2, 0);
      mw1 = 0; mw2 = 0; mr = 1; over = 0;
      while (!over) begin
        k = 0;
        while (!fight_en && k < 12) begin
          tick();
          k++;
        end
        chk("rnd_fight_reached", fight_en, 1);
        chk("rnd_round_num", round_num, mr);
        ticks($urandom_range(0, 2));
        chk("rnd_fight_hold", fight_en, 1);
        if ($urandom_range(0, 2) == 0) begin
          pause_btn = 1'b1;
          tick();
          pause_btn = 1'b0;
          chk("rnd_pause_keep", timer_keep, 1);
          hp1 = 8'd0;
          tick();
          chk("rnd_pause_ignores_ko", fight_en, 0);
          hp1 = 8'd100;
          pause_btn = 1'b1;
          tick();
          pause_btn = 1'b0;
          chk("rnd_resume", fight_en, 1);
        end
        a = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 255));
        b = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 255));
        exp_res = ref_result(a, b);
        hp1 = 8'(a); hp2 = 8'(b); timeout = 1'b1;
        tick();
        hp1 = 8'd100; hp2 = 8'd100; timeout = 1'b0;
        if (exp_res == 1 && mw1 < 2) mw1++;
        if (exp_res == 2 && mw2 < 2) mw2++;
        chk("rnd_round_result", round_result, exp_res);
        chk("rnd_wins1", wins1, mw1);
        chk("rnd_wins2", wins2, mw2);
        ticks(3);
        if (mw1 == 2 || mw2 == 2 || mr == 5) begin
          chk("rnd_match_over", match_over, 1);
          chk("rnd_match_winner", match_winner, mw1 > mw2 ? 1 : (mw2 > mw1 ? 2 : 3));
          over = 1;
        end else begin
          mr++;
          chk("rnd_next_round", round_num, mr);
          chk("rnd_intro_timer_reset", timer_reset, 1);
        end
      end
    end
  endtask

  initial begin
    #2 reset_n = 1'b0;
    #2 chk_reset_vals("por");
    tick();
    reset_n = 1'b1;
    tick();
    chk("idle_round_num", round_num, 0);
    chk("idle_timer_reset", timer_reset, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("intro_timer_reset", timer_reset, 1);
      chk("intro_hp_reset", hp_reset, 1);
      chk("intro_fight_en", fight_en, 0);
      tick();
    end
    chk("fight_en", fight_en, 1);
    chk("fight_keep", timer_keep, 0);
    chk("fight_timer_reset", timer_reset, 0);
    chk("fight_round", round_num, 1);
    hp1 = 8'd37; hp2 = 8'd0;
    tick();
    hp1 = 8'd100; hp2 = 8'd100;
    chk("ko_result", round_result, 1);
    chk("ko_wins1", wins1, 1);
    chk("ko_fight_en", fight_en, 0);
    ticks(2);
    chk("end_dwell_round", round_num, 1);
    chk("end_dwell_hp_reset", hp_reset, 0);
    tick();
    chk("r2_round", round_num, 2);
    chk("r2_hp_reset", hp_reset, 1);
    chk("r2_result_cleared", round_result, 0);
    ticks(4);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_ignored_fight", fight_en, 1);
    chk("start_ignored_round", round_num, 2);
    timeout = 1'b1; hp1 = 8'd50; hp2 = 8'd50;
    tick();
    timeout = 1'b0; hp1 = 8'd100; hp2 = 8'd100;
    chk("to_draw_result", round_result, 3);
    chk("to_draw_wins1", wins1, 1);
    chk("to_draw_wins2", wins2, 0);
    ticks(7);
    timeout = 1'b1; hp1 = 8'd0; hp2 = 8'd50;
    tick();
    timeout = 1'b0; hp1 = 8'd100; hp2 = 8'd100;
    chk("to_ko_result", round_result, 2);
    chk("to_ko_wins2", wins2, 1);
    ticks(7);
    chk("r4_round", round_num, 4);
    pause_btn = 1'b1;
    tick();
    pause_btn = 1'b0;
    chk("pause_keep", timer_keep, 1);
    chk("pause_fight_en", fight_en, 0);
    hp1 = 8'd0;
    ticks(2);
    chk("pause_hold_fe", fight_en, 0);
    chk("pause_hold_result", round_result, 0);
    pause_btn = 1'b1;
    tick();
    pause_btn = 1'b0;
    chk("resume_fight_en", fight_en, 1);
    tick();
    hp1 = 8'd100;
    chk("resume_ko_result", round_result, 2);
    chk("resume_ko_wins2", wins2, 2);
    ticks(3);
    chk("me1_match_over", match_over, 1);
    chk("me1_winner", match_winner, 2);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_wins1", wins1, 0);
    chk("restart_wins2", wins2, 0);
    chk("restart_round", round_num, 1);
    chk("restart_match_over", match_over, 0);
    ticks(4);
    hp2 = 8'd0; pause_btn = 1'b1;
    tick();
    hp2 = 8'd100; pause_btn = 1'b0;
    chk("ko_pause_result", round_result, 1);
    chk("ko_pause_wins1", wins1, 1);
    ticks(7);
    hp2 = 8'd0;
    tick();
    hp2 = 8'd100;
    chk("p1_second_win", wins1, 2);
    ticks(3);
    chk("me2_match_over", match_over, 1);
    chk("me2_winner", match_winner, 1);
    chk("me2_fight_en", fight_en, 0);
    chk("me2_keep", timer_keep, 1);
    chk("me2_timer_reset", timer_reset, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("me2_restart_wins1", wins1, 0);
    for (int r = 1; r <= 5; r++) begin
      ticks(4);
      hp1 = 8'd0; hp2 = 8'd0;
      tick();
      hp1 = 8'd100; hp2 = 8'd100;
      chk("cap_draw_result", round_result, 3);
      ticks(3);
      if (r < 5) chk("cap_next_round", round_num, r + 1);
    end
    chk("cap_match_over", match_over, 1);
    chk("cap_winner", match_winner, 3);
    begin_match();
    chk("async_pre_fight", fight_en, 1);
    #2 reset_n = 1'b0;
    #1 chk_reset_vals("async");
    tick();
    reset_n = 1'b1;
    tick();
    chk("async_idle_round", round_num, 0);
    vt.push_back('{8'd37,  8'd0,   1'b0, 1'b0, 2'd1, 1'b0, 2'd1, 2'd0});
    vt.push_back('{8'd0,   8'd99,  1'b0, 1'b0, 2'd2, 1'b0, 2'd0, 2'd1});
    vt.push_back('{8'd0,   8'd0,   1'b0, 1'b0, 2'd3, 1'b0, 2'd0, 2'd0});
    vt.push_back('{8'd50,  8'd50,  1'b1, 1'b0, 2'd3, 1'b0, 2'd0, 2'd0});
    vt.push_back('{8'd200, 8'd10,  1'b1, 1'b0, 2'd1, 1'b0, 2'd1, 2'd0});
    vt.push_back('{8'd3,   8'd4,   1'b1, 1'b0, 2'd2, 1'b0, 2'd0, 2'd1});
    vt.push_back('{8'd0,   8'd255, 1'b1, 1'b0, 2'd2, 1'b0, 2'd0, 2'd1});
    vt.push_back('{8'd10,  8'd20,  1'b0, 1'b1, 2'd0, 1'b0, 2'd0, 2'd0});
    vt.push_back('{8'd10,  8'd20,  1'b0, 1'b0, 2'd0, 1'b1, 2'd0, 2'd0});
    vt.push_back('{8'd0,   8'd5,   1'b0, 1'b1, 2'd2, 1'b0, 2'd0, 2'd1});
    vt.push_back('{8'd1,   8'd1,   1'b1, 1'b1, 2'd3, 1'b0, 2'd0, 2'd0});
    for (int i = 0; i < vt.size(); i++) begin
      do_reset();
      begin_match();
      hp1 = vt[i].h1; hp2 = vt[i].h2; timeout = vt[i].to; pause_btn = vt[i].pb;
      tick();
      hp1 = 8'd100; hp2 = 8'd100; timeout = 1'b0; pause_btn = 1'b0;
      chk("vec_result", round_result, vt[i].res);
      chk("vec_fight_en", fight_en, vt[i].fe);
      chk("vec_wins1", wins1, vt[i].w1);
      chk("vec_wins2", wins2, vt[i].w2);
    end
    rand_matches(8);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/round_ctrl.md
# round_ctrl

Match/round sequencer for the two-player fight game. It sits directly upstream of the 60 s round timer, which it drives through `timer_reset` (held during intro) and `timer_keep` (pause). It consumes the timer's sticky `timeout` plus both players' health. It decides round winners, counts wins to best-of-N, and gates player input through `fight_en`.

## Interface
- `HP_W`, 8: health bus width.
- `ROUNDS_TO_WIN`, 2: round wins that end the match.
- `MAX_ROUNDS`, 5: hard round cap, which guards against endless draws.
- `INTRO_CYCLES`, 50_000_000: "READY/FIGHT" hold time (2 s at 25 MHz).
- `END_CYCLES`, 75_000_000: round-result display hold (3 s).
- `clk` in 1: system clock (25 MHz).
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse from menu/debounce.
- `pause_btn` in 1: one-cycle pulse that toggles pause.
- `hp1`, `hp2` in HP_W: current health; 0 means KO.
- `timeout` in 1: sticky timer expiry; clears only via `timer_reset`.
- `timer_reset` out 1: registered, active-high; drives the timer's async reset.
- `timer_keep` out 1: registered; 1 freezes the timer.
- `hp_reset` out 1: registered; reloads both health counters.
- `fight_en` out 1: registered; enables player move logic.
- `round_num` out 3: current round, 1-based.
- `wins1`, `wins2` out 2: rounds won per player.
- `round_result` out 2: 00 none, 01 P1, 10 P2, 11 draw. Valid in ROUND_END/MATCH_END.
- `match_over` out 1: high in MATCH_END.
- `match_winner` out 2: same encoding as `round_result`.

## Operation
States: IDLE, INTRO, FIGHT, PAUSE, ROUND_END, MATCH_END.
- **IDLE:** `start` goes to INTRO, with wins1=wins2=0, round_num=1, round_result=00. Other inputs are ignored.
- **INTRO:** delay counter runs from 0. At count==INTRO_CYCLES-1, go to FIGHT. `start` and `pause_btn` are ignored.
- **FIGHT:** checks in priority order, with the first match winning:
  - KO: hp1==0 or hp2==0 goes to ROUND_END. Both zero is a draw; otherwise the non-zero player wins.
  - `timeout`: goes to ROUND_END. Higher hp wins; equal hp is a draw.
  - `pause_btn`: goes to PAUSE.
- **PAUSE:** `pause_btn` goes back to FIGHT. KO and timeout are not evaluated here.
- **ROUND_END:** on the entry cycle, latch round_result and increment the winner's wins. A draw increments nothing. Wins saturate at ROUNDS_TO_WIN. After END_CYCLES cycles in the state:
  - If either wins==ROUNDS_TO_WIN or round_num==MAX_ROUNDS, go to MATCH_END.
  - Otherwise round_num++, round_result=00, and go to INTRO.
- **MATCH_END:** match_winner is set to the player with more wins; equal wins is 11. `start` goes to INTRO with the same clears as from IDLE.

Registered output decode, driven from next_state so the outputs align with the state register:
- `timer_reset` = 1 in IDLE and INTRO.
- `hp_reset` = 1 in IDLE and INTRO.
- `timer_keep` = 0 only in FIGHT.
- `fight_en` = 1 only in FIGHT.
- `match_over` = 1 only in MATCH_END.

## Timing
- Reset values:
  - state IDLE
  - `timer_reset`=1, `hp_reset`=1, `timer_keep`=1
  - `fight_en`=0, `match_over`=0
  - round_num=0, wins=0, results=00
  - delay counter 0
- Transition latency is 1 cycle from a sampled input to the new state. The outputs change on the same edge.
- INTRO dwell is exactly INTRO_CYCLES cycles. ROUND_END dwell is exactly END_CYCLES cycles.
- The first FIGHT cycle has `timer_reset`=0. The timer therefore counts from 60 with a clean `timeout`=0, so a stale timeout can never end a new round.
- KO and timeout in the same cycle: KO wins; the winner is decided by the KO rule.
- KO and `pause_btn` in the same cycle: KO wins and the pause is dropped.
- `start` outside IDLE and MATCH_END has no effect.
- The delay counter is 32 bits, clears on every state entry, and never wraps within a dwell.
- `reset_n` low mid-round forces the reset values asynchronously. Because `timer_reset` is a flop output, the timer reset is glitch-free.

## Structure
- Package `kof_pkg`:
  - state enum `round_state_t`
  - result encodings `RES_NONE`/`RES_P1`/`RES_P2`/`RES_DRAW`
  - `CLK_HZ`=25_000_000
- One sub-module, `phase_delay`: a loadable down-counter with `load`, `len`, and a `done` pulse. It is shared by INTRO and ROUND_END.
- The FSM, win counters and output registers stay in `round_ctrl`.

## Test plan
Bench parameters: INTRO_CYCLES=4, END_CYCLES=3, ROUNDS_TO_WIN=2, MAX_ROUNDS=5.
- **Reset and start:** release `reset_n`, pulse `start` → 4 INTRO cycles with `timer_reset`=1, then `fight_en`=1, `timer_keep`=0, round_num=1.
- **KO:** in FIGHT drive hp2=0, hp1=37 → round_result=01 and wins1=1 next cycle. After 3 cycles: INTRO with round_num=2 and `hp_reset`=1.
- **Timeout draw:** `timeout`=1 with hp1=hp2=50 → round_result=11 and wins unchanged. A simultaneous hp1=0 instead gives result 10.
- **Pause:** `pause_btn` in FIGHT → `timer_keep`=1 and `fight_en`=0. hp1=0 while paused → no transition. A second pulse resumes and the KO is taken next cycle.
- **Match end:** P1 wins rounds 1 and 2 → MATCH_END, match_winner=01, `match_over`=1. `start` → INTRO with wins cleared.
- **Draw cap and async reset:** five draws → MATCH_END after round 5, match_winner=11. Assert `reset_n` low mid-FIGHT → outputs reach reset values without a clock edge.
